// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
// Module      : life_pkg
// Description : Shared types and helpers for the Life cellular-automaton engine.
// Revision    : 1.0 - initial release
// ============================================================================
package life_pkg;

  localparam int GEN_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_WAIT_SWAP = 2'd2
  } state_t;

  typedef logic [3:0] ncount_t;
  typedef logic [8:0] rule_t;

  function automatic ncount_t count8(input logic [7:0] v);
    ncount_t s;
    s = '0;
    for (int k = 0; k < 8; k++) s = s + ncount_t'(v[k]);
    return s;
  endfunction

  function automatic logic apply_rule(input logic alive, input ncount_t n,
                                      input rule_t birth, input rule_t survive);
    return alive ? survive[n] : birth[n];
  endfunction

endpackage
`default_nettype wire

// File: rtl/life_window.sv
`default_nettype none
// ============================================================================
// Module      : life_window
// Description : Three-row by three-word sliding window plus the per-cell
//               birth/survive lookups producing one next-generation word.
// Revision    : 1.0 - initial release
// ============================================================================
module life_window
  import life_pkg::*;
#(
  parameter int WORD_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_vld,
  input  logic [1:0]        shift_sub,
  input  logic              shift_mask,
  input  logic [WORD_W-1:0] shift_data,
  input  logic [8:0]        rule_birth,
  input  logic [8:0]        rule_survive,
  output logic [WORD_W-1:0] next_word
);

  logic [WORD_W-1:0] r_stage [2];
  logic [WORD_W-1:0] r_win_l [3];
  logic [WORD_W-1:0] r_win_c [3];
  logic [WORD_W-1:0] r_win_r [3];
  logic [WORD_W-1:0] w_data;

  assign w_data = shift_mask ? '0 : shift_data;

  // Rows 0/1 are staged; the whole column enters the window with row 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) r_stage[k] <= '0;
      for (int k = 0; k < 3; k++) begin
        r_win_l[k] <= '0;
        r_win_c[k] <= '0;
        r_win_r[k] <= '0;
      end
    end else if (shift_vld) begin
      case (shift_sub)
        2'd0: r_stage[0] <= w_data;
        2'd1: r_stage[1] <= w_data;
        2'd2: begin
          for (int k = 0; k < 3; k++) begin
            r_win_l[k] <= r_win_c[k];
            r_win_c[k] <= r_win_r[k];
          end
          r_win_r[0] <= r_stage[0];
          r_win_r[1] <= r_stage[1];
          r_win_r[2] <= w_data;
        end
        default: ;
      endcase
    end
  end

  // Extended row: bit 0 is the rightmost cell of the left word, bit WORD_W+1
  // the leftmost cell of the right word.
  logic [2:0][WORD_W+1:0] w_ext;

  for (genvar k = 0; k < 3; k++) begin : g_row
    assign w_ext[k] = {r_win_r[k][0], r_win_c[k], r_win_l[k][WORD_W-1]};
  end

  for (genvar i = 0; i < WORD_W; i++) begin : g_cell
    logic [7:0] w_nbr;
    assign w_nbr = {w_ext[0][i+2:i], w_ext[1][i+2], w_ext[1][i], w_ext[2][i+2:i]};
    assign next_word[i] = apply_rule(w_ext[1][i+1], count8(w_nbr),
                                     rule_birth, rule_survive);
  end

endmodule
`default_nettype wire

// File: rtl/life_engine.sv
`default_nettype none
// ============================================================================
// Module      : life_engine
// Description : Double-buffered Game-of-Life engine. Define LIFE_ENGINE_WRAP_EN
//               for a toroidal grid; otherwise cells beyond the edge are dead.
// Revision    : 1.0 - initial release
// ============================================================================
module life_engine
  import life_pkg::*;
#(
  parameter  int WORD_W = 20,
  parameter  int COLS_W = 64,
  parameter  int ROWS   = 1024,
  localparam int AW     = $clog2(COLS_W * ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [8:0]        rule_birth,
  input  logic [8:0]        rule_survive,
  input  logic              step_req,
  input  logic              swap_ok,
  output logic              busy,
  output logic              gen_done,
  output logic [15:0]       generation,
  input  logic              ld_en,
  input  logic [AW-1:0]     ld_addr,
  input  logic [WORD_W-1:0] ld_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  localparam int            DEPTH   = COLS_W * ROWS;
  localparam int            RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int            CW      = $clog2(COLS_W + 2);
  localparam logic [AW-1:0] COLS_AW = AW'(COLS_W);

  state_t             r_state;
  logic               r_bank_sel;
  logic               r_busy;
  logic               r_gen_done;
  logic [GEN_W-1:0]   r_generation;
  rule_t              r_rule_birth;
  rule_t              r_rule_survive;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic [1:0]         r_sub;
  logic               r_issue_done;
  logic               r_p_vld;
  logic [1:0]         r_p_sub;
  logic               r_p_mask;
  logic [RW-1:0]      r_p_row;
  logic [CW-1:0]      r_p_col;
  logic               r_w_vld;
  logic [AW-1:0]      r_w_addr;
  logic [WORD_W-1:0]  r_rd_data;
  logic [WORD_W-1:0]  r_cmp_rdata;

  logic [RW-1:0]      w_row_eff;
  logic [CW-1:0]      w_col_eff;
  logic               w_mask;
  logic [AW-1:0]      w_cmp_addr;
  logic               w_host_we;
  logic               w_cmp_we;
  logic [WORD_W-1:0]  w_next_word;
  logic [1:0][WORD_W-1:0] w_disp_rd;
  logic [1:0][WORD_W-1:0] w_cmp_rd;

  // r_col walks columns -1..COLS_W (offset by one); r_sub picks row r-1, r, r+1.
  always_comb begin
    w_row_eff = r_row;
    w_col_eff = r_col - CW'(1);
    w_mask    = 1'b0;
    case (r_sub)
      2'd0: begin
        if (r_row == '0) begin
`ifdef LIFE_ENGINE_WRAP_EN
          w_row_eff = RW'(ROWS - 1);
`else
          w_row_eff = '0;
          w_mask    = 1'b1;
`endif
        end else begin
          w_row_eff = r_row - RW'(1);
        end
      end
      2'd2: begin
        if (r_row == RW'(ROWS - 1)) begin
          w_row_eff = '0;
`ifndef LIFE_ENGINE_WRAP_EN
          w_mask    = 1'b1;
`endif
        end else begin
          w_row_eff = r_row + RW'(1);
        end
      end
      default: ;
    endcase
    if (r_col == '0) begin
`ifdef LIFE_ENGINE_WRAP_EN
      w_col_eff = CW'(COLS_W - 1);
`else
      w_col_eff = '0;
      w_mask    = 1'b1;
`endif
    end else if (r_col == CW'(COLS_W + 1)) begin
      w_col_eff = '0;
`ifndef LIFE_ENGINE_WRAP_EN
      w_mask    = 1'b1;
`endif
    end
  end

  assign w_cmp_addr = AW'(w_row_eff) * COLS_AW + AW'(w_col_eff);
  assign w_host_we  = ld_en && (r_state == ST_IDLE);
  assign w_cmp_we   = r_w_vld && (r_state == ST_RUN);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic              w_front;
    logic              w_we;
    logic [AW-1:0]     w_wa;
    logic [WORD_W-1:0] w_wd;

    assign w_front = (r_bank_sel == 1'(b));
    assign w_we    = w_front ? w_host_we : w_cmp_we;
    assign w_wa    = w_front ? ld_addr   : r_w_addr;
    assign w_wd    = w_front ? ld_data   : w_next_word;

    always_ff @(posedge clk) begin
      if (w_we) r_mem[w_wa] <= w_wd;
    end

    assign w_disp_rd[b] = r_mem[rd_addr];
    assign w_cmp_rd[b]  = r_mem[w_cmp_addr];
  end

  life_window #(
    .WORD_W (WORD_W)
  ) u_window (
    .clk          (clk),
    .reset        (reset),
    .shift_vld    (r_p_vld),
    .shift_sub    (r_p_sub),
    .shift_mask   (r_p_mask),
    .shift_data   (r_cmp_rdata),
    .rule_birth   (r_rule_birth),
    .rule_survive (r_rule_survive),
    .next_word    (w_next_word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_bank_sel     <= 1'b0;
      r_busy         <= 1'b0;
      r_gen_done     <= 1'b0;
      r_generation   <= '0;
      r_rule_birth   <= '0;
      r_rule_survive <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_sub          <= '0;
      r_issue_done   <= 1'b0;
      r_p_vld        <= 1'b0;
      r_p_sub        <= '0;
      r_p_mask       <= 1'b0;
      r_p_row        <= '0;
      r_p_col        <= '0;
      r_w_vld        <= 1'b0;
      r_w_addr       <= '0;
      r_rd_data      <= '0;
      r_cmp_rdata    <= '0;
    end else begin
      r_gen_done  <= 1'b0;
      r_rd_data   <= w_disp_rd[r_bank_sel];
      r_cmp_rdata <= w_cmp_rd[r_bank_sel];
      r_p_vld     <= (r_state == ST_RUN) && !r_issue_done;
      r_p_sub     <= r_sub;
      r_p_mask    <= w_mask;
      r_p_row     <= r_row;
      r_p_col     <= r_col;
      // A word is complete once its right-hand neighbour column has shifted in.
      r_w_vld     <= r_p_vld && (r_p_sub == 2'd2) && (r_p_col >= CW'(2));
      r_w_addr    <= AW'(r_p_row) * COLS_AW + AW'(r_p_col - CW'(2));

      case (r_state)
        ST_IDLE: begin
          if (step_req) begin
            r_rule_birth   <= rule_birth;
            r_rule_survive <= rule_survive;
            r_busy         <= 1'b1;
            r_state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!r_issue_done) begin
            if (r_sub == 2'd2) begin
              r_sub <= '0;
              if (r_col == CW'(COLS_W + 1)) begin
                r_col <= '0;
                if (r_row == RW'(ROWS - 1)) begin
                  r_row        <= '0;
                  r_issue_done <= 1'b1;
                end else begin
                  r_row <= r_row + RW'(1);
                end
              end else begin
                r_col <= r_col + CW'(1);
              end
            end else begin
              r_sub <= r_sub + 2'd1;
            end
          end else if (!r_p_vld && !r_w_vld) begin
            r_issue_done <= 1'b0;
            r_state      <= ST_WAIT_SWAP;
          end
        end
        ST_WAIT_SWAP: begin
          if (swap_ok) begin
            r_bank_sel   <= ~r_bank_sel;
            r_gen_done   <= 1'b1;
            r_generation <= r_generation + GEN_W'(1);
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign gen_done   = r_gen_done;
  assign generation = r_generation;
  assign rd_data    = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_life_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_life_engine
// Description : Scoreboard bench for life_engine against a cell-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_life_engine;

  localparam int WORD_W    = 8;
  localparam int COLS_W    = 2;
  localparam int ROWS      = 8;
  localparam int CELLS     = WORD_W * COLS_W;
  localparam int DEPTH     = COLS_W * ROWS;
  localparam int AW        = $clog2(DEPTH);
  localparam int RUN_LIMIT = 3 * DEPTH + 8 * ROWS + 16 + 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [8:0]        rule_birth = '0;
  logic [8:0]        rule_survive = '0;
  logic              step_req = 1'b0;
  logic              swap_ok = 1'b0;
  logic              busy;
  logic              gen_done;
  logic [15:0]       generation;
  logic              ld_en = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [WORD_W-1:0] ld_data = '0;
  logic [AW-1:0]     rd_addr = '0;
  logic [WORD_W-1:0] rd_data;

  life_engine #(.WORD_W(WORD_W), .COLS_W(COLS_W), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .rule_birth(rule_birth), .rule_survive(rule_survive),
    .step_req(step_req), .swap_ok(swap_ok), .busy(busy), .gen_done(gen_done),
    .generation(generation), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int gen_exp  = 0;

  typedef struct {
    int          addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  logic rd_req  = 1'b0;
  logic mon_vld = 1'b0;

  always @(posedge clk) mon_vld <= rd_req;

  always @(negedge clk) begin
    exp_t e;
    if (mon_vld) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: rd_data %h arrived with no expectation", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e.data) begin
          n_fail++;
          $display("FAIL rd_data[%0d]: got %h expected %h (gen %0d)", e.addr, rd_data, e.data, gen_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: plain cell array ----------------
  bit grid [ROWS][CELLS];

  function automatic int cell_at(int r, int c);
`ifdef LIFE_ENGINE_WRAP_EN
    return int'(grid[(r + ROWS) % ROWS][(c + CELLS) % CELLS]);
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= CELLS) return 0;
    return int'(grid[r][c]);
`endif
  endfunction

  task automatic model_step(input logic [8:0] b, input logic [8:0] s);
    bit nxt [ROWS][CELLS];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < CELLS; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) n += cell_at(r + dr, c + dc);
        nxt[r][c] = grid[r][c] ? s[n] : b[n];
      end
    grid = nxt;
  endtask

  function automatic logic [7:0] model_word(int a);
    logic [7:0] wd;
    for (int bb = 0; bb < WORD_W; bb++) wd[bb] = grid[a / COLS_W][(a % COLS_W) * WORD_W + bb];
    return wd;
  endfunction

  task automatic clear_grid();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < CELLS; c++) grid[r][c] = 1'b0;
  endtask

  task automatic random_grid(input int density);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < CELLS; c++) grid[r][c] = ($urandom_range(0, 99) < density);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic load_grid();
    for (int a = 0; a < DEPTH; a++) begin
      ld_en   = 1'b1;
      ld_addr = AW'(a);
      ld_data = model_word(a);
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      exp_t e;
      rd_addr = AW'(a);
      rd_req  = 1'b1;
      e.addr  = a;
      e.data  = model_word(a);
      exp_q.push_back(e);
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_gen();
    bit seen = 1'b0;
    for (int i = 0; i < RUN_LIMIT && !seen; i++) begin
      @(negedge clk);
      if (gen_done === 1'b1) seen = 1'b1;
    end
    check("gen_done within run bound", 32'(seen), 32'd1);
    check("busy cleared at swap", 32'(busy), 32'd0);
    check("generation count", 32'(generation), 32'(gen_exp & 16'hFFFF));
    tick();
    swap_ok = 1'b0;
  endtask

  // Step with swap_ok already high; the rule inputs are scrambled once RUN starts.
  task automatic do_step(input logic [8:0] b, input logic [8:0] s);
    rule_birth   = b;
    rule_survive = s;
    step_req     = 1'b1;
    swap_ok      = 1'b1;
    tick();
    step_req = 1'b0;
    @(negedge clk);
    check("busy after step_req", 32'(busy), 32'd1);
    check("no swap on start cycle", 32'(gen_done), 32'd0);
    rule_birth   = ~b;
    rule_survive = ~s;
    model_step(b, s);
    gen_exp++;
    wait_gen();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] rb, rs;
    int         pulses;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset gen_done", 32'(gen_done), 32'd0);
    check("reset generation", 32'(generation), 32'd0);
    check("reset rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // Blinker across the word boundary
    clear_grid();
    grid[3][6] = 1; grid[3][7] = 1; grid[3][8] = 1;
    load_grid();
    read_all();
    do_step(9'h008, 9'h00C);
    read_all();
    do_step(9'h008, 9'h00C);
    read_all();
    check("blinker generation", 32'(generation), 32'd2);

    // Block straddling the word boundary
    clear_grid();
    grid[4][7] = 1; grid[4][8] = 1; grid[5][7] = 1; grid[5][8] = 1;
    load_grid();
    for (int g = 0; g < 3; g++) begin
      do_step(9'h008, 9'h00C);
      read_all();
    end

    // Glider heading off the right edge
    clear_grid();
    grid[1][13] = 1; grid[2][14] = 1; grid[3][12] = 1; grid[3][13] = 1; grid[3][14] = 1;
    load_grid();
    for (int g = 0; g < 8; g++) begin
      do_step(9'h008, 9'h00C);
      if (g == 3 || g == 7) read_all();
    end

    // Rule latching: B0 on an empty grid
    clear_grid();
    load_grid();
    do_step(9'h001, 9'h000);
    read_all();

    // Random grids and rules
    for (int k = 0; k < 4; k++) begin
      random_grid($urandom_range(20, 60));
      load_grid();
      rb = 9'($urandom_range(0, 511));
      rs = 9'($urandom_range(0, 511));
      do_step(rb, rs);
      read_all();
      do_step(9'h008, 9'h00C);
      read_all();
    end

    // Swap handshake held off for over 500 cycles
    random_grid(40);
    load_grid();
    rb = 9'h008;
    rs = 9'h00C;
    rule_birth   = rb;
    rule_survive = rs;
    swap_ok      = 1'b0;
    step_req     = 1'b1;
    tick();
    step_req     = 1'b0;
    rule_birth   = 9'h1FF;
    rule_survive = 9'h000;
    repeat (150) tick();
    for (int k = 0; k < 5; k++) begin
      repeat (100) tick();
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      @(negedge clk);
      check("busy held in wait", 32'(busy), 32'd1);
      check("no gen_done in wait", 32'(gen_done), 32'd0);
      check("generation held in wait", 32'(generation), 32'(gen_exp & 16'hFFFF));
      tick();
    end
    read_all();
    model_step(rb, rs);
    gen_exp++;
    swap_ok = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (gen_done === 1'b1) pulses++;
      tick();
    end
    swap_ok = 1'b0;
    check("single gen_done pulse", 32'(pulses), 32'd1);
    check("busy after handshake", 32'(busy), 32'd0);
    check("generation after handshake", 32'(generation), 32'(gen_exp & 16'hFFFF));
    read_all();

    // Reset in the middle of RUN (bank 0 must be the front bank here)
    if (gen_exp % 2 != 0) begin
      do_step(9'h008, 9'h00C);
      read_all();
    end
    random_grid(35);
    load_grid();
    rule_birth   = 9'($urandom_range(0, 511));
    rule_survive = 9'($urandom_range(0, 511));
    step_req     = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (20) tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("mid-run reset busy", 32'(busy), 32'd0);
    check("mid-run reset generation", 32'(generation), 32'd0);
    check("mid-run reset gen_done", 32'(gen_done), 32'd0);
    tick();
    reset   = 1'b0;
    gen_exp = 0;
    tick();
    read_all();
    do_step(9'h008, 9'h00C);
    read_all();
    do_step(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)));
    read_all();

    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
